// File: rtl/ber_pkg.sv
// ber_pkg: shared constants, word typedefs and popcount helper for the BER datapath
package ber_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 32;
  localparam int POP_MAX = 256;
  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef logic [DEF_WIDTH-1:0] err_vec_t;
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v, input int unsigned w);
    popcount = 0;
    for (int i = 0; i < POP_MAX; i++) popcount += (i < int'(w)) ? 32'(v[i]) : 32'd0;
  endfunction
endpackage

// File: rtl/ber_error_injector.sv
// ber_error_injector: flips one walking bit every INJECT_PERIOD words while enabled
module ber_error_injector #(
  parameter int WIDTH = 8,
  parameter int INJECT_PERIOD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] mux_out,
  input  logic             inject_en,
  output logic [WIDTH-1:0] corr
);
  localparam int WC_W = INJECT_PERIOD > 1 ? $clog2(INJECT_PERIOD) : 1;
  localparam int POS_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic last, inj;
  // word counter runs free; bit position advances only when a flip is applied
  always_comb begin
    last = word_cnt_q == WC_W'(INJECT_PERIOD - 1);
    inj = inject_en && last;
    word_cnt_d = last ? '0 : word_cnt_q + 1'b1;
    pos_d = !inj ? pos_q : (pos_q == POS_W'(WIDTH - 1)) ? '0 : pos_q + 1'b1;
    corr = mux_out ^ (inj ? (WIDTH'(1) << pos_q) : '0);
  end
  // counter state
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt_q <= '0;
      pos_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      pos_q <= pos_d;
    end
  end
endmodule

// File: rtl/ber_datapath.sv
// ber_datapath: source mux, error injection, compare, popcount and running BER totals
module ber_datapath
  import ber_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INJECT_PERIOD = 4,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sel,
  input  logic [WIDTH-1:0]           test_pattern,
  input  logic [WIDTH-1:0]           normal_input,
  input  logic                       inject_en,
  output logic [WIDTH-1:0]           original,
  output logic [WIDTH-1:0]           corrupted,
  output logic [WIDTH-1:0]           error,
  output logic [$clog2(WIDTH+1)-1:0] sum_error,
  output logic [CNT_W-1:0]           bit_count,
  output logic [CNT_W-1:0]           err_count
);
  localparam int SUM_W = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mux_out, corr, err;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] original_q, original_d, corrupted_q, corrupted_d, error_q, error_d;
  logic [SUM_W-1:0] sum_error_q, sum_error_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d, err_count_q, err_count_d;

  ber_error_injector #(.WIDTH(WIDTH), .INJECT_PERIOD(INJECT_PERIOD)) u_inj (
    .clock(clock),
    .reset(reset),
    .mux_out(mux_out),
    .inject_en(inject_en),
    .corr(corr)
  );

  // select source, compare against corrupted copy, and accumulate totals (wrapping)
  always_comb begin
    mux_out = sel ? test_pattern : normal_input;
    err = mux_out ^ corr;
    sum = SUM_W'(popcount(POP_MAX'(err), WIDTH));
    original_d = mux_out;
    corrupted_d = corr;
    error_d = err;
    sum_error_d = sum;
    bit_count_d = bit_count_q + CNT_W'(WIDTH);
    err_count_d = err_count_q + CNT_W'(sum);
  end

  // single-cycle output register stage and totals
  always_ff @(posedge clock) begin
    if (reset) begin
      original_q <= '0;
      corrupted_q <= '0;
      error_q <= '0;
      sum_error_q <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      original_q <= original_d;
      corrupted_q <= corrupted_d;
      error_q <= error_d;
      sum_error_q <= sum_error_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign original = original_q;
  assign corrupted = corrupted_q;
  assign error = error_q;
  assign sum_error = sum_error_q;
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_ber_datapath.sv
// tb_ber_datapath: directed checks of injection timing, totals, mux, reset and wrap
module tb_ber_datapath;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic inject_en = 1'b0;
  logic [7:0] test_pattern = 8'h00;
  logic [7:0] normal_input = 8'h00;
  logic [7:0] a_original, a_corrupted, a_error, b_original, b_corrupted, b_error;
  logic [3:0] a_sum_error, b_sum_error;
  logic [31:0] a_bit_count, a_err_count, b_bit_count, b_err_count;
  logic [7:0] exp_err;
  logic [7:0] one = 8'h01;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ber_datapath #(.WIDTH(8), .INJECT_PERIOD(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .sel(sel),
    .test_pattern(test_pattern), .normal_input(normal_input), .inject_en(inject_en),
    .original(a_original), .corrupted(a_corrupted), .error(a_error),
    .sum_error(a_sum_error), .bit_count(a_bit_count), .err_count(a_err_count)
  );

  ber_datapath #(.WIDTH(8), .INJECT_PERIOD(1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .sel(sel),
    .test_pattern(test_pattern), .normal_input(normal_input), .inject_en(inject_en),
    .original(b_original), .corrupted(b_corrupted), .error(b_error),
    .sum_error(b_sum_error), .bit_count(b_bit_count), .err_count(b_err_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    check("rst_original", 32'(a_original), 32'h0);
    check("rst_corrupted", 32'(a_corrupted), 32'h0);
    check("rst_error", 32'(a_error), 32'h0);
    check("rst_sum", 32'(a_sum_error), 32'h0);
    check("rst_bits", a_bit_count, 32'h0);
    check("rst_errs", a_err_count, 32'h0);
    reset = 1'b0;
    sel = 1'b1;
    test_pattern = 8'hA5;
    inject_en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      step();
      exp_err = (w == 3) ? 8'h01 : (w == 7) ? 8'h02 : 8'h00;
      check($sformatf("p1_error_w%0d", w), 32'(a_error), 32'(exp_err));
      check($sformatf("p1_corr_w%0d", w), 32'(a_corrupted), 32'(8'hA5 ^ exp_err));
      check($sformatf("p1_sum_w%0d", w), 32'(a_sum_error), (exp_err != 0) ? 32'd1 : 32'd0);
      check($sformatf("p1_orig_w%0d", w), 32'(a_original), 32'hA5);
    end
    check("p1_bits", a_bit_count, 32'd64);
    check("p1_errs", a_err_count, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    inject_en = 1'b0;
    sel = 1'b0;
    normal_input = 8'h3C;
    for (int w = 0; w < 10; w++) begin
      step();
      check($sformatf("p2_error_w%0d", w), 32'(a_error), 32'h0);
      check($sformatf("p2_corr_w%0d", w), 32'(a_corrupted), 32'h3C);
    end
    check("p2_errs", a_err_count, 32'd0);
    check("p2_bits", a_bit_count, 32'd80);
    test_pattern = 8'hFF;
    normal_input = 8'h00;
    for (int i = 0; i < 4; i++) begin
      sel = (i % 2) == 1;
      step();
      check($sformatf("mux_orig_%0d", i), 32'(a_original), (i % 2 == 1) ? 32'hFF : 32'h00);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    sel = 1'b1;
    test_pattern = 8'hA5;
    inject_en = 1'b1;
    for (int w = 0; w < 5; w++) begin
      step();
      check($sformatf("mid_error_w%0d", w), 32'(a_error), (w == 3) ? 32'h01 : 32'h00);
    end
    reset = 1'b1;
    step();
    check("mid_rst_original", 32'(a_original), 32'h0);
    check("mid_rst_corrupted", 32'(a_corrupted), 32'h0);
    check("mid_rst_error", 32'(a_error), 32'h0);
    check("mid_rst_sum", 32'(a_sum_error), 32'h0);
    check("mid_rst_bits", a_bit_count, 32'h0);
    check("mid_rst_errs", a_err_count, 32'h0);
    check("mid_rst_errs_p1", b_err_count, 32'h0);
    reset = 1'b0;
    for (int w = 0; w < 9; w++) begin
      step();
      exp_err = (w == 3) ? 8'h01 : (w == 7) ? 8'h02 : 8'h00;
      check($sformatf("post_error_w%0d", w), 32'(a_error), 32'(exp_err));
      exp_err = one << (w % 8);
      check($sformatf("walk_error_w%0d", w), 32'(b_error), 32'(exp_err));
      check($sformatf("walk_corr_w%0d", w), 32'(b_corrupted), 32'(8'hA5 ^ exp_err));
      check($sformatf("walk_sum_w%0d", w), 32'(b_sum_error), 32'd1);
    end
    check("walk_errs", b_err_count, 32'd9);
    check("walk_bits", b_bit_count, 32'd72);
    @(negedge clock);
    force dut.bit_count_q = 32'hFFFF_FFF8;
    #1;
    release dut.bit_count_q;
    step();
    check("wrap_bits0", a_bit_count, 32'h0);
    step();
    check("wrap_bits8", a_bit_count, 32'h8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ber_datapath.md
Name: ber_datapath

Overview:
- Receive/compare datapath of the integrated bit-error-ratio tester.
- Selects either the internal test pattern or the normal data word, and deliberately injects single-bit errors to produce a corrupted copy.
- Compares the corrupted word against the selected original, reporting the per-word error vector, the per-word error count, and running totals of bits compared and bits in error.
- Sits between the pattern generator and the BER control/reporting logic.

Parameters:
- WIDTH, 8, data word width in bits.
- INJECT_PERIOD, 4, number of words per injection interval; legal range is 1 or more.
- CNT_W, 32, width of the running bit and error totals.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  source select: 1 = test_pattern, 0 = normal_input.
- test_pattern  in  WIDTH  word from the pattern generator.
- normal_input  in  WIDTH  normal traffic word.
- inject_en  in  1  1 = error injection active; 0 = corrupted equals original.
- original  out  WIDTH  registered selected word.
- corrupted  out  WIDTH  registered selected word after injection.
- error  out  WIDTH  registered original XOR corrupted.
- sum_error  out  clog2(WIDTH+1)  registered popcount of error (0..WIDTH).
- bit_count  out  CNT_W  total bits compared since reset.
- err_count  out  CNT_W  total bit errors since reset.

Behaviour:
- One word is processed on every clock cycle while reset is low. There is no valid or handshake signal.
- Combinational path, evaluated from the current inputs:
  - mux_out = sel ? test_pattern : normal_input.
  - inj = inject_en AND (word_cnt == INJECT_PERIOD-1).
  - corr = mux_out XOR (inj ? (1 << pos) : 0).
  - err = mux_out XOR corr.
  - sum = popcount(err).
- Latency is exactly 1 cycle. At each rising edge, original, corrupted, error and sum_error load mux_out, corr, err and sum.
- Totals:
  - bit_count += WIDTH every cycle.
  - err_count += sum every cycle.
  - Both wrap modulo 2^CNT_W; no saturation and no overflow flag.
- Internal state:
  - word_cnt counts 0..INJECT_PERIOD-1. It increments every cycle and wraps to 0 after INJECT_PERIOD-1. It advances regardless of inject_en.
  - pos is a clog2(WIDTH)-bit counter. It increments modulo WIDTH only on cycles where inj = 1.
- Injection properties:
  - At most one bit flips per word, so sum_error is always 0 or 1 under this injector.
  - With INJECT_PERIOD = 1, every word is corrupted while inject_en = 1.
- Reset (synchronous; a reset asserted mid-stream takes effect at the next edge):
  - original, corrupted, error, sum_error, bit_count, err_count, word_cnt and pos all go to 0.
  - The first post-reset word is word index 0.
  - The first injection lands on word index INJECT_PERIOD-1, flipping bit 0.
- sel and inject_en may change every cycle. Each takes effect for the word sampled at that edge.
- Changing sel never resets any counter.

Decomposition:
- Shared package ber_pkg:
  - WIDTH and CNT_W default constants.
  - popcount function, parameterised on width.
  - Error-vector and word typedefs.
- One sub-module, ber_error_injector. It holds word_cnt and pos, takes mux_out and inject_en, and produces corr.
- The source mux, compare, popcount and accumulators stay in ber_datapath.

Test Plan:
- Reset, then sel=1, test_pattern=8'hA5, inject_en=1 for 8 cycles:
  - words 0-2: error=0, corrupted=A5.
  - word 3: error=8'h01, corrupted=A4, sum_error=1.
  - word 7: error=8'h02, corrupted=A7.
  - after 8 words: bit_count=64, err_count=2.
- inject_en=0, sel=0, normal_input=8'h3C for 10 cycles: error=0 and corrupted=3C throughout; err_count=0; bit_count=80.
- Mux switch, alternating sel each cycle with test_pattern=8'hFF and normal_input=8'h00: original follows the selection with 1-cycle latency.
- Pos wrap, INJECT_PERIOD=1 with inject_en=1 for 9 words: error walks 01, 02, 04, ..., 80, then 01 again; err_count=9.
- Reset mid-run after 5 words: the next edge zeroes all outputs and counters, and the next injection lands on post-reset word 3 at bit 0.
- Counter wrap, with the bench forcing bit_count to 2^32-8: one more word gives bit_count=0.
